harmonic_mix_scheduler: RTL and testbench
=========================================

// Module: harmonic_mix_scheduler
// PURPOSE
//  Time-multiplexes one shared 4096-entry sine wavetable ROM across NUM_HARM harmonic phase accumulators.
//  On each sample strobe it sweeps harmonics k=1..NUM_HARM, reads the ROM, scales each read by a per-harmonic gain
//  and outputs one summed, saturated 16-bit sample.
//  It sits between the note/frequency source and the audio output path.
//  It replaces one ROM copy per harmonic oscillator.
// PARAMETERS
//  NUM_HARM  8   number of harmonics swept per sample (1..16)
//  PHASE_W   24  phase accumulator / freq width
//  ADDR_W    12  ROM address width (phase[PHASE_W-1 -: ADDR_W])
//  SAMPLE_W  16  signed ROM word and output width
//  GAIN_W    8   unsigned per-harmonic gain; scale = gain/2^GAIN_W
// PORTS
//  Clk        in   1          system clock
//  Reset      in   1          synchronous, active-high
//  CS         in   1          block enable; low = held cleared
//  sample_Clk in   1          one-Clk-wide sample strobe
//  freq       in   PHASE_W    fundamental phase increment
//  gain_we    in   1          gain table write enable
//  gain_idx   in   4          harmonic index (0 = fundamental)
//  gain_data  in   GAIN_W     gain value written
//  rom_addr   out  ADDR_W     shared wavetable address (registered)
//  rom_data   in   SAMPLE_W   signed ROM word, valid 1 Clk after rom_addr
//  mix_out    out  SAMPLE_W   signed mixed sample, held between updates
//  mix_valid  out  1          1-Clk pulse when mix_out updates
//  busy       out  1          high from strobe acceptance until mix_valid
//  overrun    out  1          sticky: strobe arrived while busy
// BEHAVIOUR
//  Reset: state IDLE; all phases 0; rom_addr, mix_out, mix_valid, busy, overrun = 0.
//   Gains reset to gain[0]=2^GAIN_W-1, all others 0.
//  CS low (Reset not asserted): same as Reset except the gain table and overrun are preserved.
//   mix_out is forced to 0 combinationally while CS=0.
//  FSM: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//   IDLE: on sample_Clk & CS, latch freq into f_lat, clear acc, set k=0 and inc=f_lat, go to RUN.
//   RUN, one harmonic per cycle:
//    rom_addr <= phase[k][PHASE_W-1 -: ADDR_W]; phase[k] <= phase[k] + inc; inc <= inc + f_lat.
//    So harmonic k advances by (k+1)*f_lat mod 2^PHASE_W, with no multiplier.
//    After k = NUM_HARM-1, go to DRAIN.
//   MAC, each cycle after an address issue (RUN cycles 2..N and the DRAIN cycle):
//    acc += signed(rom_data) * signed({1'b0, gain[k_d]}), where k_d is k delayed 1 cycle.
//   DRAIN: final ROM word accumulated; go to DONE.
//   DONE: mix_out <= sat_SAMPLE_W(acc >>> GAIN_W); mix_valid=1 for this cycle; busy falls; go to IDLE.
//  Latency: strobe at cycle T -> mix_valid at T+NUM_HARM+3.
//  Widths:
//   product is SAMPLE_W+GAIN_W+1 bits;
//   acc is SAMPLE_W+GAIN_W+1+clog2(NUM_HARM) bits, which cannot overflow;
//   saturation clamps to [-32768, 32767].
//  Phase and inc arithmetic wraps modulo 2^PHASE_W; wrap is silent.
//  sample_Clk while busy: ignored (no restart, phases untouched) and sets overrun. Only Reset clears overrun.
//  sample_Clk in the same cycle as mix_valid (DONE): ignored, sets overrun.
//  freq changes mid-sweep have no effect until the next strobe (f_lat).
//  Gain writes are accepted in any state, including while CS=0.
//   A write lands on the next Clk.
//   A write to gain[k_d] in the cycle that MAC reads it: MAC uses the old value.
//   gain_idx >= NUM_HARM: ignored.
//  CS falling mid-sweep: abort to IDLE next Clk, no mix_valid, phases cleared.
//  Reset mid-sweep: same abort; gains and overrun are also reset.
// STRUCTURE
//  synth_pkg: PHASE_W, ADDR_W, SAMPLE_W, GAIN_W constants; typedef enum {IDLE,RUN,DRAIN,DONE} mix_state_t;
//   sat16 function.
//  Sub-module harm_mac: registered signed MAC with clear, accumulate enable and a saturating output stage.
//  Phase bank and gain table are register arrays inside this module; the ROM stays external.
// TESTING
//  1. NUM_HARM=8, reset gains, freq=24'h001000, ROM = phase index as value:
//     -> after strobes 1,2,3, rom_addr for k=0 is 0x000, 0x001, 0x002.
//     -> k=2 addresses are 0x000, 0x003, 0x006.
//     -> mix_valid exactly 11 Clk after each strobe.
//  2. ROM constant 16'h7FFF, all gains 0xFF -> acc exceeds range; mix_out=16'h7FFF.
//     ROM 16'h8000 -> mix_out=16'h8000.
//  3. gain[0]=0x80, others 0, rom_data=16'h4000 -> mix_out=16'h2000.
//  4. Second strobe 4 Clk after the first -> overrun=1, single mix_valid, phases advanced once; overrun stays 1 until Reset.
//  5. CS dropped at RUN k=3 -> no mix_valid, busy=0 next Clk, mix_out=0, gains unchanged on next CS=1 sweep.
//  6. freq=24'hFFF000, 300 strobes -> phase wrap per harmonic matches a modulo-2^24 reference model bit-exactly.

Source files
------------

// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared widths, FSM encoding and saturation helper for the harmonic mixer
package synth_pkg;
  localparam int PHASE_W  = 24;
  localparam int ADDR_W   = 12;
  localparam int SAMPLE_W = 16;
  localparam int GAIN_W   = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } mix_state_t;

  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767) return 16'sh7FFF;
    if (v < -32'sd32768) return 16'sh8000;
    return v[SAMPLE_W-1:0];
  endfunction
endpackage

// File: rtl/harm_mac.sv
// rtl/harm_mac.sv - signed multiply-accumulate of ROM words by unsigned gains with saturating output register
module harm_mac
  import synth_pkg::*;
#(
  parameter int ACC_W = 28
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       clr_i,
  input  logic                       en_i,
  input  logic                       load_i,
  input  logic signed [SAMPLE_W-1:0] data_i,
  input  logic        [GAIN_W-1:0]   gain_i,
  output logic signed [SAMPLE_W-1:0] mix_o
);
  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_shr;
  logic signed [SAMPLE_W-1:0] mix_q;

  // Gain gets a zero sign bit so it multiplies as a non-negative signed value.
  assign prod    = PROD_W'(data_i) * PROD_W'($signed({1'b0, gain_i}));
  assign acc_shr = acc_q >>> GAIN_W;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc_q <= '0;
      mix_q <= '0;
    end else begin
      if (clr_i) begin
        acc_q <= '0;
      end else if (en_i) begin
        acc_q <= acc_q + ACC_W'(prod);
      end
      if (load_i) begin
        mix_q <= sat16(32'(acc_shr));
      end
    end
  end

  assign mix_o = mix_q;
endmodule

// File: rtl/harmonic_mix_scheduler.sv
// rtl/harmonic_mix_scheduler.sv - sweeps NUM_HARM phase accumulators over one shared sine ROM
// and mixes the gain-scaled reads into one saturated sample per strobe.
module harmonic_mix_scheduler
  import synth_pkg::*;
#(
  parameter int NUM_HARM = 8
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       CS,
  input  logic                       sample_Clk,
  input  logic        [PHASE_W-1:0]  freq,
  input  logic                       gain_we,
  input  logic        [3:0]          gain_idx,
  input  logic        [GAIN_W-1:0]   gain_data,
  output logic        [ADDR_W-1:0]   rom_addr,
  input  logic signed [SAMPLE_W-1:0] rom_data,
  output logic signed [SAMPLE_W-1:0] mix_out,
  output logic                       mix_valid,
  output logic                       busy,
  output logic                       overrun
);
  localparam int K_W   = (NUM_HARM > 1) ? $clog2(NUM_HARM) : 1;
  localparam int ACC_W = SAMPLE_W + GAIN_W + 1 + $clog2(NUM_HARM);
  localparam logic [K_W-1:0] K_LAST = K_W'(NUM_HARM - 1);

  mix_state_t                 state_q, state_d;
  logic [K_W-1:0]             k_q, k_dly_q;
  logic                       mac_en_q;
  logic [PHASE_W-1:0]         f_lat_q, inc_q;
  logic [PHASE_W-1:0]         phase_q [NUM_HARM];
  logic [GAIN_W-1:0]          gain_q  [NUM_HARM];
  logic [ADDR_W-1:0]          rom_addr_q;
  logic                       mix_valid_q, busy_q, overrun_q;
  logic                       soft_clr, accept, gain_hit;
  logic signed [SAMPLE_W-1:0] mac_mix;

  assign soft_clr = Reset | ~CS;
  // A strobe landing on the mix_valid cycle is treated as a collision, not a new sweep.
  assign accept   = (state_q == IDLE) & ~mix_valid_q & sample_Clk;
  assign gain_hit = gain_we & (32'(gain_idx) < NUM_HARM);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (k_q == K_LAST) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (soft_clr) begin
      state_q     <= IDLE;
      k_q         <= '0;
      k_dly_q     <= '0;
      mac_en_q    <= 1'b0;
      f_lat_q     <= '0;
      inc_q       <= '0;
      rom_addr_q  <= '0;
      mix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < NUM_HARM; i++) phase_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      mac_en_q    <= (state_q == RUN);
      k_dly_q     <= k_q;
      mix_valid_q <= (state_q == DONE);
      if (state_q == IDLE && accept) begin
        f_lat_q <= freq;
        inc_q   <= freq;
        k_q     <= '0;
        busy_q  <= 1'b1;
      end
      // inc walks f, 2f, 3f... so harmonic k steps by (k+1)*f without a multiplier.
      if (state_q == RUN) begin
        rom_addr_q   <= phase_q[k_q][PHASE_W-1 -: ADDR_W];
        phase_q[k_q] <= phase_q[k_q] + inc_q;
        inc_q        <= inc_q + f_lat_q;
        k_q          <= k_q + 1'b1;
      end
      if (state_q == DONE) busy_q <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_HARM; i++) gain_q[i] <= '0;
      gain_q[0] <= '1;
    end else if (gain_hit) begin
      gain_q[gain_idx[K_W-1:0]] <= gain_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      overrun_q <= 1'b0;
    end else if (CS && sample_Clk && (busy_q || mix_valid_q)) begin
      overrun_q <= 1'b1;
    end
  end

  harm_mac #(.ACC_W(ACC_W)) u_mac (
    .Clk    (Clk),
    .Reset  (soft_clr),
    .clr_i  (accept),
    .en_i   (mac_en_q),
    .load_i (state_q == DONE),
    .data_i (rom_data),
    .gain_i (gain_q[k_dly_q]),
    .mix_o  (mac_mix)
  );

  assign rom_addr  = rom_addr_q;
  assign mix_out   = CS ? mac_mix : '0;
  assign mix_valid = mix_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_harmonic_mix_scheduler.sv
// tb/tb_harmonic_mix_scheduler.sv - scoreboard bench for harmonic_mix_scheduler
module tb_harmonic_mix_scheduler;
  localparam int NH = 8;

  logic        Clk = 1'b0;
  logic        Reset, CS, sample_Clk, gain_we;
  logic [23:0] freq;
  logic [3:0]  gain_idx;
  logic [7:0]  gain_data;
  logic [11:0] rom_addr;
  logic [15:0] rom_data, mix_out;
  logic        mix_valid, busy, overrun;

  logic        rom_const_mode;
  logic [15:0] rom_const;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q [$];
  logic [11:0] addr_q [$];
  logic [23:0] m_ph   [NH];
  logic [7:0]  m_gain [NH];
  logic [11:0] cap0, cap2;

  always #5 Clk = ~Clk;

  assign rom_data = rom_const_mode ? rom_const : {4'h0, rom_addr};

  harmonic_mix_scheduler #(.NUM_HARM(NH)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .CS         (CS),
    .sample_Clk (sample_Clk),
    .freq       (freq),
    .gain_we    (gain_we),
    .gain_idx   (gain_idx),
    .gain_data  (gain_data),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .mix_out    (mix_out),
    .mix_valid  (mix_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] rom_model(input logic [11:0] a);
    return rom_const_mode ? rom_const : {4'h0, a};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NH; k++) begin
      m_ph[k]   = '0;
      m_gain[k] = '0;
    end
    m_gain[0] = 8'hFF;
  endtask

  task automatic model_sweep(output logic [15:0] res);
    longint acc;
    longint s;
    logic [11:0] a;
    logic [15:0] d;
    acc = 0;
    for (int k = 0; k < NH; k++) begin
      a = m_ph[k][23:12];
      addr_q.push_back(a);
      d = rom_model(a);
      acc += longint'($signed(d)) * longint'(m_gain[k]);
      m_ph[k] = 24'((longint'(m_ph[k]) + longint'(k + 1) * longint'(freq)) % 64'sd16777216);
    end
    s = acc >>> 8;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    res = 16'(s);
  endtask

  task automatic wr_gain(input logic [3:0] idx, input logic [7:0] v);
    @(negedge Clk);
    gain_we = 1'b1; gain_idx = idx; gain_data = v;
    @(negedge Clk);
    gain_we = 1'b0;
    if (idx < 4'(NH)) m_gain[idx[2:0]] = v;
  endtask

  task automatic do_strobe(input bit use_hand, input logic [15:0] hv);
    logic [15:0] r;
    int n;
    @(negedge Clk);
    sample_Clk = 1'b1;
    model_sweep(r);
    exp_q.push_back(use_hand ? hv : r);
    @(negedge Clk);
    sample_Clk = 1'b0;
    n = 1;
    while (mix_valid !== 1'b1 && n < 40) begin
      @(negedge Clk);
      n++;
      if (n == 2) cap0 = rom_addr;
      if (n == 4) cap2 = rom_addr;
    end
    check("latency", n, 11);
    @(negedge Clk);
  endtask

  initial begin : monitor
    logic busy_prev;
    int cnt;
    logic [15:0] e;
    logic [11:0] ea;
    busy_prev = 1'b0;
    cnt = NH;
    forever begin
      @(negedge Clk);
      if (mix_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mix_valid_unexpected: got mix_out 0x%0h expected no pulse", mix_out);
        end else begin
          e = exp_q.pop_front();
          check("mix_out", 32'(mix_out), 32'(e));
        end
      end
      if (busy === 1'b1 && !busy_prev) begin
        cnt = 0;
      end else if (busy === 1'b1 && cnt < NH) begin
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rom_addr_unexpected: got 0x%0h expected no issue", rom_addr);
        end else begin
          ea = addr_q.pop_front();
          check("rom_addr", 32'(rom_addr), 32'(ea));
        end
        cnt++;
      end
      busy_prev = (busy === 1'b1);
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] r;
    int n;
    logic [7:0] gt [NH];
    gt = '{8'd255, 8'd200, 8'd150, 8'd100, 8'd80, 8'd60, 8'd40, 8'd20};
    Reset = 1'b1; CS = 1'b0; sample_Clk = 1'b0; freq = '0;
    gain_we = 1'b0; gain_idx = '0; gain_data = '0;
    rom_const_mode = 1'b0; rom_const = '0;
    model_reset();
    repeat (3) @(negedge Clk);
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_mix_out", 32'(mix_out), 0);
    check("rst_mix_valid", 32'(mix_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);
    Reset = 1'b0; CS = 1'b1;
    @(negedge Clk);

    // phase addressing per harmonic with reset gains
    freq = 24'h001000;
    do_strobe(0, '0);
    check("k0_addr_s1", 32'(cap0), 32'h000); check("k2_addr_s1", 32'(cap2), 32'h000);
    do_strobe(0, '0);
    check("k0_addr_s2", 32'(cap0), 32'h001); check("k2_addr_s2", 32'(cap2), 32'h003);
    do_strobe(0, '0);
    check("k0_addr_s3", 32'(cap0), 32'h002); check("k2_addr_s3", 32'(cap2), 32'h006);

    // saturation both ways
    for (int k = 0; k < NH; k++) wr_gain(4'(k), 8'hFF);
    rom_const_mode = 1'b1;
    rom_const = 16'h7FFF; do_strobe(1, 16'h7FFF);
    rom_const = 16'h8000; do_strobe(1, 16'h8000);

    // half-scale gain, out-of-range index writes ignored
    wr_gain(4'd0, 8'h80);
    for (int k = 1; k < NH; k++) wr_gain(4'(k), 8'h00);
    wr_gain(4'd9, 8'hFF);
    wr_gain(4'd15, 8'hFF);
    rom_const = 16'h4000; do_strobe(1, 16'h2000);

    // strobe while busy
    rom_const_mode = 1'b0;
    for (int k = 0; k < NH; k++) wr_gain(4'(k), gt[k]);
    freq = 24'h123456;
    check("overrun_pre", 32'(overrun), 0);
    @(negedge Clk);
    sample_Clk = 1'b1; model_sweep(r); exp_q.push_back(r);
    @(negedge Clk); sample_Clk = 1'b0;
    repeat (3) @(negedge Clk);
    sample_Clk = 1'b1;
    @(negedge Clk); sample_Clk = 1'b0;
    check("overrun_set", 32'(overrun), 1);
    check("busy_during_overrun", 32'(busy), 1);
    repeat (30) @(negedge Clk);
    do_strobe(0, '0);
    check("overrun_sticky", 32'(overrun), 1);

    // CS drop mid-sweep
    freq = 24'h0ABCDE;
    @(negedge Clk);
    sample_Clk = 1'b1;
    for (int k = 0; k < 3; k++) addr_q.push_back(m_ph[k][23:12]);
    @(negedge Clk); sample_Clk = 1'b0;
    repeat (3) @(negedge Clk);
    CS = 1'b0;
    @(negedge Clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_mix_valid", 32'(mix_valid), 0);
    check("abort_mix_out", 32'(mix_out), 0);
    check("abort_rom_addr", 32'(rom_addr), 0);
    for (int k = 0; k < NH; k++) m_ph[k] = '0;
    wr_gain(4'd1, 8'h33);
    repeat (3) @(negedge Clk);
    CS = 1'b1;
    do_strobe(0, '0);
    check("overrun_kept_cs", 32'(overrun), 1);

    // long run across phase wrap
    freq = 24'hFFF000;
    for (int i = 0; i < 300; i++) do_strobe(0, '0);

    // only Reset clears overrun; gains return to defaults
    @(negedge Clk); Reset = 1'b1;
    @(negedge Clk); Reset = 1'b0;
    model_reset();
    check("overrun_cleared", 32'(overrun), 0);
    check("busy_after_reset", 32'(busy), 0);

    // strobe coinciding with mix_valid
    freq = 24'h00F00F;
    @(negedge Clk);
    sample_Clk = 1'b1; model_sweep(r); exp_q.push_back(r);
    @(negedge Clk); sample_Clk = 1'b0;
    n = 1;
    while (mix_valid !== 1'b1 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    check("latency_done_case", n, 11);
    sample_Clk = 1'b1;
    @(negedge Clk); sample_Clk = 1'b0;
    check("overrun_on_done", 32'(overrun), 1);
    check("busy_done_strobe", 32'(busy), 0);
    repeat (20) @(negedge Clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("addr_q_drained", addr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
